btb_port_sched: RTL

- Scheduler in front of the 32-entry direct-mapped BTB.
- The BTB has one PC port, shared by fetch lookups and EX-stage updates. This block decides each cycle which requester drives it.
- Resolved-branch updates are buffered in a small FIFO and drained when fetch is idle, or forced in when the FIFO fills or starvation hits.
- Sits between the IF stage, the EX branch-resolve logic and the BTB instance.

---
 rtl/btb_port_sched_if.sv | 29 ++
 rtl/btb_port_sched.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/btb_port_sched_if.sv
// BTB port scheduler bus: fetch request, EX update offer, BTB drive.
// master = requesters/BTB side, slave = scheduler.
interface btb_port_sched_if;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        fetch_stall;
  logic        lookup_valid;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_ready;
  logic [31:0] btb_pc_in;
  logic        btb_update;
  logic [31:0] btb_real_target;

  modport master (
    output fetch_valid, fetch_pc,
    output upd_valid, upd_pc, upd_target,
    input  fetch_stall, lookup_valid, upd_ready,
    input  btb_pc_in, btb_update, btb_real_target
  );

  modport slave (
    input  fetch_valid, fetch_pc,
    input  upd_valid, upd_pc, upd_target,
    output fetch_stall, lookup_valid, upd_ready,
    output btb_pc_in, btb_update, btb_real_target
  );
endinterface

// File: rtl/btb_port_sched.sv
// Shares the single BTB PC port between fetch lookups and queued EX updates.
// Ports: clk, reset (async low), bus (slave), q_count; stat_* with BTB_SCHED_STATS_EN.
module btb_port_sched #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  btb_port_sched_if.slave        bus,
  output logic [$clog2(DEPTH):0] q_count
`ifdef BTB_SCHED_STATS_EN
  ,
  output logic [31:0]            stat_forced,
  output logic [31:0]            stat_coalesced,
  output logic [31:0]            stat_stall_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [31:0]   pc_q  [DEPTH];
  logic [31:0]   tgt_q [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [SW-1:0] starve;
  logic          lookup_q;

  logic          empty;
  logic          full;
  logic          g_upd;
  logic          g_fetch;
  logic          push;
  logic          pop;
  logic          hit;
  logic          coal;
  logic [AW-1:0] hit_idx;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  assign g_upd = !empty &&
                 (!bus.fetch_valid || full ||
                  starve == SW'(STARVE_LIMIT));
  assign g_fetch = !g_upd && bus.fetch_valid;

  assign bus.upd_ready = reset && !full;
  assign push = bus.upd_valid && bus.upd_ready;
  assign pop  = g_upd;

  // The head leaving this cycle cannot absorb a push.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && CW'(i) < count && !(i == 0 && pop) &&
          pc_q[head + AW'(i)] == bus.upd_pc) begin
        hit     = 1'b1;
        hit_idx = head + AW'(i);
      end
    end
  end

  assign coal = push && hit;

  always_comb begin
    bus.btb_pc_in       = '0;
    bus.btb_update      = 1'b0;
    bus.btb_real_target = '0;
    bus.fetch_stall     = 1'b0;
    unique case (1'b1)
      g_upd: begin
        bus.btb_pc_in       = pc_q[head];
        bus.btb_update      = 1'b1;
        bus.btb_real_target = tgt_q[head];
        bus.fetch_stall     = bus.fetch_valid;
      end
      g_fetch: begin
        bus.btb_pc_in = bus.fetch_pc;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      starve   <= '0;
      lookup_q <= 1'b0;
    end else begin
      if (pop)
        head <= head + AW'(1);
      if (push && !coal)
        tail <= tail + AW'(1);
      count <= count + CW'(push && !coal) - CW'(pop);
      if (g_upd || empty)
        starve <= '0;
      else if (g_fetch && starve != SW'(STARVE_LIMIT))
        starve <= starve + SW'(1);
      lookup_q <= g_fetch;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      if (hit) begin
        tgt_q[hit_idx] <= bus.upd_target;
      end else begin
        pc_q[tail]  <= bus.upd_pc;
        tgt_q[tail] <= bus.upd_target;
      end
    end
  end

  assign bus.lookup_valid = lookup_q;
  assign q_count          = count;

`ifdef BTB_SCHED_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_forced       <= '0;
      stat_coalesced    <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (g_upd && bus.fetch_valid)
        stat_forced <= stat_forced + 32'd1;
      if (coal)
        stat_coalesced <= stat_coalesced + 32'd1;
      if (bus.fetch_stall)
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
